qc_inverse_shifter: RTL

QC_INVERSE_SHIFTER -- requirements
Module: qc_inverse_shifter

---
 rtl/qc_ldpc_pkg.sv | 10 +
 rtl/qc_inverse_shift_stage.sv | 52 +++++
 rtl/qc_inverse_shifter.sv | 113 +++++++++++
 3 files changed

// File: rtl/qc_ldpc_pkg.sv
// rtl/qc_ldpc_pkg.sv - shared sizing constants and types for the QC-LDPC shifter datapath
package qc_ldpc_pkg;
  localparam int QC_MAXZ    = 81;
  localparam int QC_NS      = $clog2(QC_MAXZ);
  localparam int QC_SHIFT_W = $clog2(QC_MAXZ);
  localparam int QC_Z_W     = $clog2(QC_MAXZ + 1);

  typedef logic [QC_SHIFT_W-1:0] shift_t;
  typedef logic [QC_Z_W-1:0]     zsize_t;
endpackage

// File: rtl/qc_inverse_shift_stage.sv
// rtl/qc_inverse_shift_stage.sv - one registered right-shift level of the inverse rotator
// Shifts the doubled vector right by 2**LEVEL when amount bit LEVEL is set; everything else rides along.
module qc_inverse_shift_stage
  import qc_ldpc_pkg::*;
#(
  parameter int MAXZ  = QC_MAXZ,
  parameter int LEVEL = 0
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [2*MAXZ-1:0]     i_data,
  input  logic [QC_SHIFT_W-1:0] i_amt,
  input  logic [MAXZ-1:0]       i_mask,
  input  logic                  i_err,
  output logic                  o_valid,
  output logic [2*MAXZ-1:0]     o_data,
  output logic [QC_SHIFT_W-1:0] o_amt,
  output logic [MAXZ-1:0]       o_mask,
  output logic                  o_err
);

  logic                  r_valid;
  logic [2*MAXZ-1:0]     r_data;
  logic [QC_SHIFT_W-1:0] r_amt;
  logic [MAXZ-1:0]       r_mask;
  logic                  r_err;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_mask  <= '0;
      r_err   <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_amt[LEVEL] ? (i_data >> (2 ** LEVEL)) : i_data;
      r_amt   <= i_amt;
      r_mask  <= i_mask;
      r_err   <= i_err;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;
  assign o_mask  = r_mask;
  assign o_err   = r_err;

endmodule

// File: rtl/qc_inverse_shifter.sv
// rtl/qc_inverse_shifter.sv - pipelined left-rotate of a z-bit sub-block within MAXZ bits
// Optional request checking is enabled by defining QC_INVERSE_SHIFTER_CHECK_EN.
module qc_inverse_shifter
  import qc_ldpc_pkg::*;
#(
  parameter int MAXZ = QC_MAXZ
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAXZ-1:0]       in_data,
  input  logic [QC_SHIFT_W-1:0] in_shift,
  input  logic [QC_Z_W-1:0]     in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAXZ-1:0]       out_data,
  output logic                  out_err
);

  localparam int DW = 2 * MAXZ;

  logic                  w_adv;
  logic                  w_err;
  logic [MAXZ-1:0]       w_mask;
  logic [DW-1:0]         w_x;
  logic [DW-1:0]         w_d;
  logic [QC_SHIFT_W-1:0] w_amt;

  logic                  r_valid;
  logic [DW-1:0]         r_data;
  logic [QC_SHIFT_W-1:0] r_amt;
  logic [MAXZ-1:0]       r_mask;
  logic                  r_err;

  logic                  w_stg_valid [0:QC_NS];
  logic [DW-1:0]         w_stg_data  [0:QC_NS];
  logic [QC_SHIFT_W-1:0] w_stg_amt   [0:QC_NS];
  logic [MAXZ-1:0]       w_stg_mask  [0:QC_NS];
  logic                  w_stg_err   [0:QC_NS];

  // One enable for the whole pipe: it only stalls when the output is held.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Rotate-left by s == rotate-right by z-s over the doubled vector x | x<<z.
  always_comb begin
    w_err = 1'b0;
`ifdef QC_INVERSE_SHIFTER_CHECK_EN
    w_err = (in_z == '0) || (int'(in_z) > MAXZ) || (zsize_t'(in_shift) >= in_z);
`endif
    w_mask = '0;
    for (int i = 0; i < MAXZ; i++) begin
      w_mask[i] = !w_err && (i < int'(in_z));
    end
    w_x   = {{MAXZ{1'b0}}, in_data & w_mask};
    w_d   = w_x | (w_x << in_z);
    w_amt = (in_shift == '0) ? '0 : shift_t'(in_z) - in_shift;
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_mask  <= '0;
      r_err   <= 1'b0;
    end else if (w_adv) begin
      r_valid <= in_valid;
      r_data  <= w_d;
      r_amt   <= w_amt;
      r_mask  <= w_mask;
      r_err   <= w_err;
    end
  end

  assign w_stg_valid[0] = r_valid;
  assign w_stg_data[0]  = r_data;
  assign w_stg_amt[0]   = r_amt;
  assign w_stg_mask[0]  = r_mask;
  assign w_stg_err[0]   = r_err;

  for (genvar k = 0; k < QC_NS; k++) begin : g_lvl
    qc_inverse_shift_stage #(
      .MAXZ  (MAXZ),
      .LEVEL (k)
    ) u_stage (
      .CLK     (CLK),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_stg_valid[k]),
      .i_data  (w_stg_data[k]),
      .i_amt   (w_stg_amt[k]),
      .i_mask  (w_stg_mask[k]),
      .i_err   (w_stg_err[k]),
      .o_valid (w_stg_valid[k+1]),
      .o_data  (w_stg_data[k+1]),
      .o_amt   (w_stg_amt[k+1]),
      .o_mask  (w_stg_mask[k+1]),
      .o_err   (w_stg_err[k+1])
    );
  end

  assign out_valid = w_stg_valid[QC_NS];
  assign out_data  = w_stg_data[QC_NS][MAXZ-1:0] & w_stg_mask[QC_NS];

`ifdef QC_INVERSE_SHIFTER_CHECK_EN
  assign out_err = w_stg_err[QC_NS];
`else
  assign out_err = 1'b0;
`endif

endmodule
